mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer and arbiter placing the instruction-fetch path and the load/store path onto the single-port 1024×20 data RAM. It latches the winning address and write data into internal MAR/MDR registers, drives the RAM address, write data and write-select lines, and returns read data with a one-cycle acknowledge. It sits between the fetch stage, the execute stage and the RAM inside the memory subsystem.

## Interface
- ADDR_W, 10, address width (RAM depth 2^ADDR_W)
- DATA_W, 20, word width
- RAM_LAT, 1, RAM read latency in cycles, legal 1..3
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_ack  out  1  one-cycle pulse, fetch done
- if_data  out  DATA_W  instruction word, valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse, load/store done
- d_rdata  out  DATA_W  load data, valid with d_ack
- ram_addr  out  ADDR_W  to RAM, equals MAR
- ram_wdata  out  DATA_W  to RAM, equals MDR
- ram_wr  out  1  RAM write-select
- ram_rdata  in  DATA_W  from RAM
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: if no request, stay. If exactly one request, grant it. If both, round-robin: grant the requester not granted last; the last-grant flag resets to "data", so fetch wins the first tie after reset.
- On grant: MAR <= winner address; MDR <= d_wdata on a store; owner flag records fetch/data. Fetch or load -> READ; store -> WRITE.
- READ: wait counter loaded with RAM_LAT-1; on counter zero, capture ram_rdata into the owner's data register -> RESP.
- WRITE: ram_wr = 1 for exactly this one cycle -> RESP.
- RESP: owner's ack = 1 for one cycle; data register holds its value until the next capture -> IDLE.
- ram_wr is 0 in every state except WRITE. ram_addr/ram_wdata always reflect MAR/MDR.
- Requests are sampled only in IDLE. A requester dropping req mid-transaction does not abort: the access completes and ack still pulses.
- Fetch never writes; d_we is ignored for fetch.
- Reset (reset = 0 at an edge), including mid-transaction: state IDLE, MAR = 0, MDR = 0, wait counter = 0, last-grant = data, if_ack = d_ack = 0, if_data = d_rdata = 0, ram_wr = 0, busy = 0. An in-flight store whose WRITE cycle has not yet occurred is discarded; no ack is issued for an aborted access.

## Timing
- Edge E0 in IDLE with a request -> READ/WRITE from E0.
- Load/fetch: data captured at edge E0+RAM_LAT; ack high during cycle E0+RAM_LAT..E0+RAM_LAT+1. Request-to-ack latency is RAM_LAT+1 edges.
- Store: RAM write at edge E0+1; ack during cycle E0+1..E0+2.
- Back-to-back: after RESP returns to IDLE, a held request is granted at the next edge. Peak throughput is one read per RAM_LAT+2 cycles and one store per 3 cycles.
- Addresses wrap naturally at ADDR_W bits with no extension; no arithmetic is performed on addresses.

## Structure
- Shared package: state encoding (2-bit enum), owner encoding (FETCH/DATA), default widths ADDR_W/DATA_W.
- One sub-module, `mac_grant`: combinational round-robin picker plus the last-grant flop. The rest (FSM, MAR/MDR, wait counter, output registers) lives in the top.

## Test plan
- Reset then single fetch: preload RAM[0x005] = 0xABCDE; if_req with if_addr = 0x005 -> if_ack for one cycle at request edge + 2 (RAM_LAT = 1) with if_data = 0xABCDE; busy high for 2 cycles.
- Store then load: d_we = 1, d_addr = 0x3FF, d_wdata = 0x12345 -> ram_wr high for one cycle with ram_addr = 0x3FF, d_ack one cycle later. Then a load of 0x3FF returns d_rdata = 0x12345.
- Contention: if_req and d_req asserted together and held -> grant order fetch, data, fetch, data. Exactly one ack per transaction; acks never overlap.
- RAM_LAT = 3: a load of preloaded address 0x010 gives d_ack at request edge + 4. Data is stable until the next capture.
- Reset mid-store: assert reset in the cycle after a store grant, before WRITE -> RAM location unchanged, no d_ack, all outputs 0, state IDLE.
- Requester withdraws: if_req dropped one cycle after grant -> if_ack still pulses with the correct data; controller then idles with busy = 0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access controller: FSM state encoding,
// access owner encoding, default widths and the round-robin pick rule.
package mem_access_ctrl_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 20;
    localparam int DEF_RAM_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // On a tie the requester that did not win last time gets the RAM.
    function automatic owner_t rr_pick(input logic if_req, input logic d_req, input owner_t last);
        if (if_req && d_req)
            return (last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        else if (if_req)
            return OWN_FETCH;
        else
            return OWN_DATA;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the fetch/execute requesters, the RAM and the controller.
// master = requesters plus RAM, slave = the controller.
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_data;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_ack, if_data, d_ack, d_rdata, ram_addr, ram_wdata, ram_wr
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_ack, if_data, d_ack, d_rdata, ram_addr, ram_wdata, ram_wr
    );
endinterface

// File: rtl/mem_access_ctrl_grant.sv
// Round-robin picker between fetch and data requests, plus the flop
// remembering who won the previous grant.
module mac_grant
    import mem_access_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   grant_en,
    input  logic   if_req,
    input  logic   d_req,
    output logic   grant_valid,
    output owner_t grant_owner
);

    owner_t last_reg;

    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = rr_pick(if_req, d_req, last_reg);
    end

    // Starts as "data" so fetch wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset)
            last_reg <= OWN_DATA;
        else if (grant_en && grant_valid)
            last_reg <= grant_owner;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer placing fetch and load/store accesses onto a single-port RAM
// through MAR/MDR, returning read data with a one-cycle acknowledge.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RAM_LAT = DEF_RAM_LAT
)(
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus,
    output logic              busy
);

    localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

    state_t            state_reg;
    state_t            state_next;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [DATA_W-1:0] mdr_reg;
    logic [1:0]        wait_reg;
    logic              grant_valid;
    owner_t            grant_owner;
    logic              grant_store;
    logic              read_done;

    mac_grant u_grant (
        .clk         (clk),
        .reset       (reset),
        .grant_en    (state_reg == ST_IDLE),
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant_store = (grant_owner == OWN_DATA) && bus.d_we;
    assign read_done   = (state_reg == ST_READ) && (wait_reg == 2'd0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_valid) state_next = grant_store ? ST_WRITE : ST_READ;
            ST_READ:  if (wait_reg == 2'd0) state_next = ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_DATA;
            mar_reg   <= '0;
            mdr_reg   <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && grant_valid) begin
                owner_reg <= grant_owner;
                mar_reg   <= (grant_owner == OWN_FETCH) ? bus.if_addr : bus.d_addr;
                wait_reg  <= WAIT_INIT;
                if (grant_store)
                    mdr_reg <= bus.d_wdata;
            end else if (state_reg == ST_READ && wait_reg != 2'd0) begin
                wait_reg <= wait_reg - 2'd1;
            end
        end
    end

    // Index 0 serves the fetch port, index 1 the data port.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] rdata_reg;
        logic              ack_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                rdata_reg <= '0;
                ack_reg   <= 1'b0;
            end else begin
                ack_reg <= (state_next == ST_RESP) && (owner_reg == owner_t'(1'(gi)));
                if (read_done && owner_reg == owner_t'(1'(gi)))
                    rdata_reg <= bus.ram_rdata;
            end
        end
    end

    // A store whose write edge coincides with reset must not reach the RAM.
    assign bus.ram_wr    = (state_reg == ST_WRITE) && reset;
    assign bus.ram_addr  = mar_reg;
    assign bus.ram_wdata = mdr_reg;
    assign bus.if_ack    = g_port[0].ack_reg;
    assign bus.if_data   = g_port[0].rdata_reg;
    assign bus.d_ack     = g_port[1].ack_reg;
    assign bus.d_rdata   = g_port[1].rdata_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (RAM_LAT 1 and 3) with behavioural
// RAMs, randomized traffic checked against a reference memory and timing rules.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy1, busy3;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(10), .DATA_W(20)) bus1 ();
    mem_access_ctrl_if #(.ADDR_W(10), .DATA_W(20)) bus3 ();

    mem_access_ctrl #(.ADDR_W(10), .DATA_W(20), .RAM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1));
    mem_access_ctrl #(.ADDR_W(10), .DATA_W(20), .RAM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .busy(busy3));

    // RAM models and reference memories
    logic [19:0] mem1 [1024];
    logic [19:0] mem3 [1024];
    logic [19:0] ref1 [1024];
    logic [19:0] ref3 [1024];
    logic [19:0] rd3_p0, rd3_p1;
    logic        pre_we = 1'b0, pre_sel = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [19:0] pre_data = '0;

    always @(posedge clk) begin
        if (bus1.ram_wr) mem1[bus1.ram_addr] <= bus1.ram_wdata;
        else if (pre_we && !pre_sel) mem1[pre_addr] <= pre_data;
        if (bus3.ram_wr) mem3[bus3.ram_addr] <= bus3.ram_wdata;
        else if (pre_we && pre_sel) mem3[pre_addr] <= pre_data;
        rd3_p0 <= mem3[bus3.ram_addr];
        rd3_p1 <= rd3_p0;
    end
    assign bus1.ram_rdata = mem1[bus1.ram_addr];
    assign bus3.ram_rdata = rd3_p1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic preload(input bit sel, input logic [9:0] a, input logic [19:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_sel = sel; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        if (sel) ref3[a] = d; else ref1[a] = d;
    endtask

    task automatic drive(input bit sel, input bit fr, input bit dr, input bit we,
                         input logic [9:0] fa, input logic [9:0] da, input logic [19:0] wd);
        if (sel) begin
            bus3.if_req = fr; bus3.if_addr = fa; bus3.d_req = dr;
            bus3.d_we = we; bus3.d_addr = da; bus3.d_wdata = wd;
        end else begin
            bus1.if_req = fr; bus1.if_addr = fa; bus1.d_req = dr;
            bus1.d_we = we; bus1.d_addr = da; bus1.d_wdata = wd;
        end
    endtask

    task automatic observe(input bit sel, output logic fack, output logic dack,
                           output logic [19:0] fdat, output logic [19:0] ddat,
                           output logic wr, output logic [9:0] ra, output logic bz);
        if (sel) begin
            fack = bus3.if_ack; dack = bus3.d_ack; fdat = bus3.if_data; ddat = bus3.d_rdata;
            wr = bus3.ram_wr; ra = bus3.ram_addr; bz = busy3;
        end else begin
            fack = bus1.if_ack; dack = bus1.d_ack; fdat = bus1.if_data; ddat = bus1.d_rdata;
            wr = bus1.ram_wr; ra = bus1.ram_addr; bz = busy1;
        end
    endtask

    // One request (kind 0 fetch, 1 load, 2 store); reports what was observed.
    task automatic xact(input bit sel, input int kind, input logic [9:0] addr, input logic [19:0] wdata,
                        output int edges, output logic [19:0] rdata, output bit timed_out,
                        output int wr_cycles, output logic [9:0] wr_addr, output int busy_cnt,
                        output int other_acks);
        logic fack, dack, wr, bz;
        logic [19:0] fdat, ddat;
        logic [9:0] ra;
        @(negedge clk);
        drive(sel, kind == 0, kind != 0, (kind == 2) ? 1'b1 : ((kind == 0) ? 1'($urandom) : 1'b0),
              addr, addr, wdata);
        edges = 0; timed_out = 1'b1; wr_cycles = 0; wr_addr = '0; busy_cnt = 0;
        other_acks = 0; rdata = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            edges++;
            observe(sel, fack, dack, fdat, ddat, wr, ra, bz);
            if (bz) busy_cnt++;
            if (wr) begin wr_cycles++; wr_addr = ra; end
            if ((kind == 0) ? dack : fack) other_acks++;
            if ((kind == 0) ? fack : dack) begin
                timed_out = 1'b0;
                rdata = (kind == 0) ? fdat : ddat;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0, addr, addr, wdata);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) $display("FAIL reset_busy: got %b/%b expected 0/0", busy1, busy3); else passes++;
        checks++; if ({bus1.if_ack, bus1.d_ack, bus1.ram_wr} !== 3'b000) $display("FAIL reset_acks: got %b expected 000", {bus1.if_ack, bus1.d_ack, bus1.ram_wr}); else passes++;
        checks++; if ({bus1.if_data, bus1.d_rdata} !== 40'd0) $display("FAIL reset_data: got %h expected 0", {bus1.if_data, bus1.d_rdata}); else passes++;
        checks++; if ({bus1.ram_addr, bus1.ram_wdata} !== 30'd0) $display("FAIL reset_mar_mdr: got %h expected 0", {bus1.ram_addr, bus1.ram_wdata}); else passes++;
        checks++; if ({bus3.if_ack, bus3.d_ack, bus3.ram_wr, bus3.ram_addr} !== 13'd0) $display("FAIL reset_lat3: got %h expected 0", {bus3.if_ack, bus3.d_ack, bus3.ram_wr, bus3.ram_addr}); else passes++;
    endtask

    task automatic test_single_fetch;
        int e, wc, bc, oa; bit to; logic [19:0] rd; logic [9:0] wa;
        preload(1'b0, 10'h005, 20'hABCDE);
        xact(1'b0, 0, 10'h005, 20'h0, e, rd, to, wc, wa, bc, oa);
        checks++; if (to || e != 2) $display("FAIL fetch_latency: got %0d (timeout %0d) expected 2", e, to); else passes++;
        checks++; if (rd !== 20'hABCDE) $display("FAIL fetch_data: got %h expected abcde", rd); else passes++;
        checks++; if (bc != 2) $display("FAIL fetch_busy: got %0d cycles expected 2", bc); else passes++;
        checks++; if (wc != 0 || oa != 0) $display("FAIL fetch_side: got wr=%0d dack=%0d expected 0/0", wc, oa); else passes++;
        @(negedge clk);
        checks++; if (bus1.if_ack !== 1'b0 || busy1 !== 1'b0) $display("FAIL fetch_pulse: got ack=%b busy=%b expected 0/0", bus1.if_ack, busy1); else passes++;
        $display("fetch 0x005 -> %h in %0d edges", rd, e);
    endtask

    task automatic test_store_load;
        int e, wc, bc, oa; bit to; logic [19:0] rd; logic [9:0] wa;
        xact(1'b0, 2, 10'h3FF, 20'h12345, e, rd, to, wc, wa, bc, oa);
        ref1[10'h3FF] = 20'h12345;
        checks++; if (wc != 1 || wa !== 10'h3FF) $display("FAIL store_wr: got %0d cycles addr %h expected 1 at 3ff", wc, wa); else passes++;
        checks++; if (to || e != 2) $display("FAIL store_ack: got %0d (timeout %0d) expected 2", e, to); else passes++;
        checks++; if (mem1[10'h3FF] !== 20'h12345) $display("FAIL store_ram: got %h expected 12345", mem1[10'h3FF]); else passes++;
        xact(1'b0, 1, 10'h3FF, 20'h0, e, rd, to, wc, wa, bc, oa);
        checks++; if (to || e != 2 || rd !== 20'h12345) $display("FAIL load_back: got %h in %0d expected 12345 in 2", rd, e); else passes++;
        $display("store/load 0x3ff -> %h", rd);
    endtask

    task automatic test_random;
        int e, wc, bc, oa, kind, lat; bit to, sel; logic [19:0] rd, wd, expd; logic [9:0] wa, a;
        for (int n = 0; n < 40; n++) begin
            sel  = 1'($urandom);
            kind = $urandom_range(0, 2);
            a    = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 31));
            if (kind != 2 && a == 10'h3FF && sel) a = 10'h01F;
            wd   = 20'($urandom);
            lat  = sel ? 3 : 1;
            expd = sel ? ref3[a] : ref1[a];
            xact(sel, kind, a, wd, e, rd, to, wc, wa, bc, oa);
            checks++;
            if (to || e != ((kind == 2) ? 2 : lat + 1))
                $display("FAIL rand_latency[%0d]: got %0d (timeout %0d) expected %0d", n, e, to, (kind == 2) ? 2 : lat + 1);
            else passes++;
            checks++; if (oa != 0 || wc != ((kind == 2) ? 1 : 0)) $display("FAIL rand_side[%0d]: got wr=%0d other_ack=%0d", n, wc, oa); else passes++;
            if (kind == 2) begin
                if (sel) ref3[a] = wd; else ref1[a] = wd;
                checks++;
                if ((sel ? mem3[a] : mem1[a]) !== wd) $display("FAIL rand_store[%0d]: got %h expected %h", n, sel ? mem3[a] : mem1[a], wd);
                else passes++;
            end else begin
                checks++; if (rd !== expd) $display("FAIL rand_read[%0d]: got %h expected %h", n, rd, expd); else passes++;
            end
            $display("rand %0d lat%0d kind %0d addr %h -> %h in %0d edges", n, lat, kind, a, (kind == 2) ? wd : rd, e);
        end
    endtask

    task automatic test_contention;
        int n, last_cyc; bit exp_fetch;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 10'h003, 10'h004, 20'h0);
        n = 0; last_cyc = 0; exp_fetch = 1'b1;
        for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus1.if_ack && bus1.d_ack) begin
                checks++; $display("FAIL contention_overlap: both acks high at cycle %0d", cyc);
            end else if (bus1.if_ack || bus1.d_ack) begin
                checks++;
                if (bus1.if_ack !== exp_fetch) $display("FAIL contention_order[%0d]: got fetch=%b expected %b", n, bus1.if_ack, exp_fetch);
                else passes++;
                checks++;
                if ((bus1.if_ack ? bus1.if_data : bus1.d_rdata) !== (bus1.if_ack ? ref1[3] : ref1[4]))
                    $display("FAIL contention_data[%0d]: got %h expected %h", n,
                             bus1.if_ack ? bus1.if_data : bus1.d_rdata, bus1.if_ack ? ref1[3] : ref1[4]);
                else passes++;
                checks++;
                if (cyc - last_cyc != ((n == 0) ? 2 : 3)) $display("FAIL contention_spacing[%0d]: got %0d expected %0d", n, cyc - last_cyc, (n == 0) ? 2 : 3);
                else passes++;
                $display("contention grant %0d fetch=%b at cycle %0d", n, bus1.if_ack, cyc);
                last_cyc = cyc; exp_fetch = ~exp_fetch; n++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h003, 10'h004, 20'h0);
        checks++; if (n != 4) $display("FAIL contention_count: got %0d acks expected 4", n); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (busy1 !== 1'b0) $display("FAIL contention_idle: got busy %b expected 0", busy1); else passes++;
    endtask

    task automatic test_withdraw;
        bit seen; logic [19:0] rd;
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h005, 10'h0, 20'h0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h005, 10'h0, 20'h0);
        seen = 1'b0; rd = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus1.if_ack) begin seen = 1'b1; rd = bus1.if_data; end
            else @(negedge clk);
        end
        checks++; if (!seen || rd !== ref1[5]) $display("FAIL withdraw_ack: got seen=%b data %h expected %h", seen, rd, ref1[5]); else passes++;
        repeat (3) begin
            @(negedge clk);
            checks++; if (busy1 !== 1'b0 || bus1.if_ack !== 1'b0) $display("FAIL withdraw_idle: got busy=%b ack=%b expected 0/0", busy1, bus1.if_ack); else passes++;
        end
        $display("withdrawn fetch 0x005 -> %h", rd);
    endtask

    task automatic test_reset_mid_store;
        bit dack_seen;
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h0, 10'h007, ~ref1[7]);
        @(negedge clk); reset = 1'b0; drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h007, 20'h0);
        dack_seen = 1'b0;
        repeat (3) begin @(negedge clk); if (bus1.d_ack) dack_seen = 1'b1; end
        checks++; if (dack_seen) $display("FAIL midstore_ack: got d_ack expected none"); else passes++;
        checks++;
        if ({busy1, bus1.if_ack, bus1.d_ack, bus1.ram_wr, bus1.if_data, bus1.d_rdata, bus1.ram_addr, bus1.ram_wdata} !== 74'd0)
            $display("FAIL midstore_outputs: got %h expected 0",
                     {busy1, bus1.if_ack, bus1.d_ack, bus1.ram_wr, bus1.if_data, bus1.d_rdata, bus1.ram_addr, bus1.ram_wdata});
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mem1[7] !== ref1[7]) $display("FAIL midstore_ram: got %h expected %h", mem1[7], ref1[7]); else passes++;
        checks++; if (busy1 !== 1'b0) $display("FAIL midstore_idle: got busy %b expected 0", busy1); else passes++;
        $display("reset mid-store: ram[007] = %h", mem1[7]);
    endtask

    task automatic test_lat3_hold;
        int e, wc, bc, oa; bit to; logic [19:0] rd; logic [9:0] wa;
        preload(1'b1, 10'h010, 20'h5A5A5);
        xact(1'b1, 1, 10'h010, 20'h0, e, rd, to, wc, wa, bc, oa);
        checks++; if (to || e != 4) $display("FAIL lat3_latency: got %0d (timeout %0d) expected 4", e, to); else passes++;
        checks++; if (rd !== 20'h5A5A5) $display("FAIL lat3_data: got %h expected 5a5a5", rd); else passes++;
        checks++; if (bc != 4) $display("FAIL lat3_busy: got %0d expected 4", bc); else passes++;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus3.d_rdata !== 20'h5A5A5 || bus3.d_ack !== 1'b0)
                $display("FAIL lat3_hold: got data %h ack %b expected 5a5a5/0", bus3.d_rdata, bus3.d_ack);
            else passes++;
        end
        $display("lat3 load 0x010 -> %h in %0d edges", rd, e);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 20'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 20'h0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            preload(1'b0, 10'(i), 20'($urandom));
            preload(1'b1, 10'(i), 20'($urandom));
        end
        test_reset();
        reset = 1'b1;
        test_single_fetch();
        test_store_load();
        test_random();
        test_contention();
        test_withdraw();
        test_reset_mid_store();
        test_lat3_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
